// File: rtl/noc_pkg.sv
// noc_pkg: shared network-on-chip constants and flit layout
package noc_pkg;
    localparam int PORTS = 4;
    localparam int WIDTH = 8;
    typedef struct packed {
        logic [PORTS-1:0] dest;
        logic [WIDTH-1:0] data;
    } flit_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with occupancy count and combinational head
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd];
    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= wdata;
    end
endmodule

// File: rtl/crossbar_input_buffer.sv
// crossbar_input_buffer: per-input flit queue with multicast completion tracking
module crossbar_input_buffer
    import noc_pkg::*;
#(
    parameter int PORTS = noc_pkg::PORTS,
    parameter int WIDTH = noc_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [PORTS-1:0]       in_dest,
    output logic [PORTS-1:0]       dest,
    output logic [WIDTH-1:0]       data_o,
    input  logic [PORTS-1:0]       ack,
    output logic [$clog2(DEPTH):0] count
);
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [PORTS-1:0] head_dest;
    logic [WIDTH-1:0] head_data;
    logic [PORTS-1:0] served;
    logic [PORTS-1:0] eff;
    sync_fifo #(.WIDTH(PORTS + WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_dest, in_data}),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  ({head_dest, head_data})
    );
    // a zero-destination flit completes its handshake but is never stored
    always_comb begin
        in_ready = !full;
        push     = in_valid && in_ready && |in_dest;
        dest     = empty ? '0 : head_dest & ~served;
        data_o   = empty ? '0 : head_data;
        eff      = ack & dest;
        pop      = !empty && ((served | eff) == head_dest);
    end
    // accumulate outputs that took the head; clear when the head retires
    always_ff @(posedge clk) begin
        if (rst || pop) served <= '0;
        else served <= served | eff;
    end
endmodule

// File: tb/tb_crossbar_input_buffer.sv
// tb_crossbar_input_buffer: randomized and directed checks against a queue model
module tb_crossbar_input_buffer;
    localparam int PORTS = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    logic             clk = 0;
    logic             rst = 1;
    logic             in_valid = 0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [PORTS-1:0] in_dest = '0;
    logic [PORTS-1:0] dest;
    logic [WIDTH-1:0] data_o;
    logic [PORTS-1:0] ack = '0;
    logic [2:0]       count;
    int checks = 0;
    int passed = 0;
    logic [WIDTH-1:0] q_data [$];
    logic [PORTS-1:0] q_owed [$];

    crossbar_input_buffer #(.PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .dest(dest), .data_o(data_o),
        .ack(ack), .count(count)
    );

    always #5 clk = ~clk;

    // model: each queued flit keeps the set of outputs it still owes
    task automatic tick();
        logic [PORTS-1:0] left;
        bit room;
        room = q_data.size() < DEPTH;
        if (rst) begin
            q_data.delete();
            q_owed.delete();
        end else begin
            if (q_data.size() > 0) begin
                left = q_owed[0] & ~ack;
                if (left == '0) begin
                    void'(q_data.pop_front());
                    void'(q_owed.pop_front());
                end else q_owed[0] = left;
            end
            if (in_valid && room && in_dest != '0) begin
                q_data.push_back(in_data);
                q_owed.push_back(in_dest);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (dest !== 4'b0) $display("FAIL reset_dest got %b want 0000", dest); else passed++;
        checks++; if (data_o !== 8'h00) $display("FAIL reset_data got %h want 00", data_o); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
        checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        ack = '0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h10 + 8'(i);
            in_dest = 4'b0011;
            tick();
        end
        in_valid = 0;
        checks++; if (count !== 3'd3) $display("FAIL prereset_count got %0d want 3", count); else passed++;
        rst = 1;
        tick();
        rst = 0;
        checks++; if (count !== 3'd0) $display("FAIL midreset_count got %0d want 0", count); else passed++;
        checks++; if (dest !== 4'b0) $display("FAIL midreset_dest got %b want 0000", dest); else passed++;
    endtask

    task automatic test_unicast();
        logic [WIDTH-1:0] d [3] = '{8'h42, 8'h43, 8'h44};
        logic [PORTS-1:0] m [3] = '{4'b0001, 4'b0010, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            in_valid = i < 3;
            in_data  = i < 3 ? d[i] : 8'h00;
            in_dest  = i < 3 ? m[i] : 4'b0;
            ack      = dest;
            tick();
            if (i < 3) begin
                checks++; if (data_o !== d[i]) $display("FAIL uni_data%0d got %h want %h", i, data_o, d[i]); else passed++;
                checks++; if (dest !== m[i]) $display("FAIL uni_dest%0d got %b want %b", i, dest, m[i]); else passed++;
                checks++; if (count !== 3'd1) $display("FAIL uni_count%0d got %0d want 1", i, count); else passed++;
            end else begin
                checks++; if (count !== 3'd0) $display("FAIL uni_drain got %0d want 0", count); else passed++;
            end
        end
        in_valid = 0;
        ack = '0;
    endtask

    task automatic test_multicast();
        in_valid = 1; in_data = 8'h20; in_dest = 4'b0101; ack = 4'b1010;
        tick();
        in_valid = 0;
        checks++; if (dest !== 4'b0101) $display("FAIL mc_dest0 got %b want 0101", dest); else passed++;
        checks++; if (data_o !== 8'h20) $display("FAIL mc_data got %h want 20", data_o); else passed++;
        ack = 4'b1011;
        tick();
        checks++; if (dest !== 4'b0100) $display("FAIL mc_dest1 got %b want 0100", dest); else passed++;
        checks++; if (count !== 3'd1) $display("FAIL mc_count1 got %0d want 1", count); else passed++;
        ack = 4'b1010;
        tick();
        checks++; if (dest !== 4'b0100) $display("FAIL mc_spurious got %b want 0100", dest); else passed++;
        ack = 4'b1110;
        tick();
        checks++; if (count !== 3'd0) $display("FAIL mc_pop got %0d want 0", count); else passed++;
        in_valid = 1; in_data = 8'h21; in_dest = 4'b0101; ack = '0;
        tick();
        in_valid = 0;
        checks++; if (dest !== 4'b0101) $display("FAIL mc_served_clear got %b want 0101", dest); else passed++;
        ack = 4'b0101;
        tick();
        ack = '0;
        checks++; if (count !== 3'd0) $display("FAIL mc_both got %0d want 0", count); else passed++;
    endtask

    task automatic test_full();
        ack = '0;
        in_valid = 1;
        in_dest = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h50 + 8'(i);
            checks++; if (in_ready !== (i < 4)) $display("FAIL full_ready%0d got %b want %b", i, in_ready, i < 4); else passed++;
            tick();
            checks++; if (count > 3'd4) $display("FAIL full_over%0d got %0d want <=4", i, count); else passed++;
        end
        checks++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else passed++;
        ack = 4'b0001;
        tick();
        checks++; if (count !== 3'd3) $display("FAIL full_poponly got %0d want 3", count); else passed++;
        ack = '0;
        tick();
        in_valid = 0;
        checks++; if (count !== 3'd4) $display("FAIL full_held got %0d want 4", count); else passed++;
        ack = 4'b0001;
        for (int i = 1; i < 5; i++) begin
            checks++; if (data_o !== 8'h50 + 8'(i)) $display("FAIL full_order%0d got %h want %h", i, data_o, 8'h50 + 8'(i)); else passed++;
            tick();
        end
        ack = '0;
        checks++; if (count !== 3'd0) $display("FAIL full_drain got %0d want 0", count); else passed++;
    endtask

    task automatic test_zero_wrap();
        logic [WIDTH-1:0] sent [$];
        in_valid = 1; in_data = 8'hAA; in_dest = 4'b0000;
        checks++; if (in_ready !== 1'b1) $display("FAIL zero_ready got %b want 1", in_ready); else passed++;
        tick();
        in_valid = 0;
        checks++; if (count !== 3'd0) $display("FAIL zero_count got %0d want 0", count); else passed++;
        checks++; if (dest !== 4'b0) $display("FAIL zero_dest got %b want 0000", dest); else passed++;
        for (int i = 0; i < 11; i++) begin
            in_valid = i < 10;
            in_data  = 8'($urandom);
            in_dest  = 4'b1 << $urandom_range(0, 3);
            ack      = dest;
            if (i < 10) sent.push_back(in_data);
            tick();
            if (i < 10) begin
                checks++; if (data_o !== sent[i]) $display("FAIL wrap_data%0d got %h want %h", i, data_o, sent[i]); else passed++;
            end
        end
        in_valid = 0;
        ack = '0;
        checks++; if (count !== 3'd0) $display("FAIL wrap_drain got %0d want 0", count); else passed++;
    endtask

    task automatic test_random();
        logic [PORTS-1:0] e_dest;
        logic [WIDTH-1:0] e_data;
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data  = 8'($urandom);
            in_dest  = 4'($urandom);
            ack      = 4'($urandom);
            rst      = $urandom_range(0, 99) == 0;
            tick();
            rst = 0;
            e_dest = q_data.size() > 0 ? q_owed[0] : '0;
            e_data = q_data.size() > 0 ? q_data[0] : '0;
            checks++; if (dest !== e_dest) $display("FAIL rnd_dest%0d got %b want %b", i, dest, e_dest); else passed++;
            checks++; if (data_o !== e_data) $display("FAIL rnd_data%0d got %h want %h", i, data_o, e_data); else passed++;
            checks++; if (count !== 3'(q_data.size())) $display("FAIL rnd_count%0d got %0d want %0d", i, count, q_data.size()); else passed++;
            checks++; if (in_ready !== (q_data.size() < DEPTH)) $display("FAIL rnd_ready%0d got %b want %b", i, in_ready, q_data.size() < DEPTH); else passed++;
        end
        in_valid = 0;
        ack = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_unicast();
        test_multicast();
        test_full();
        test_zero_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
